// File: rtl/dec_seq_pkg.sv
// Shared mode and state encodings for the sequenced select-line decoder.
package dec_seq_pkg;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_THERM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_SCAN = 2'b10
    } state_e;

    function automatic logic is_scan_mode(input logic [1:0] m);
        return (m == MODE_UP) || (m == MODE_DOWN);
    endfunction

endpackage

// File: rtl/dec_onehot_comb.sv
// Combinational SEL_W-to-2^SEL_W decoder: one-hot or thermometer (bits [idx:0] set).
module dec_onehot_comb #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      idx_next,
    input  logic                  therm,
    output logic [(1<<SEL_W)-1:0] y_next
);
    localparam int OUT_W = 1 << SEL_W;

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign y_next[i] = therm ? (SEL_W'(i) <= idx_next) : (SEL_W'(i) == idx_next);
    end

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered decoder with hold/scan sequencing, programmable dwell and wrap/busy flags.
module dec_onehot_seq
    import dec_seq_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap,
    output logic                  busy
);
    localparam int OUT_W = 1 << SEL_W;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_q, y_d, y_dec;
    logic               wrap_q, wrap_d;
    logic               busy_q;
    logic               therm_d, clr_y, scan_req;

    assign scan_req = is_scan_mode(mode);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        clr_y   = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            clr_y   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = scan_req ? ST_SCAN : ST_HOLD;
                    idx_d   = sel_in;
                    cnt_d   = '0;
                end
                ST_HOLD: begin
                    // Entering SCAN continues from the held index, not sel_in.
                    if (scan_req) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end else begin
                        idx_d = sel_in;
                    end
                end
                ST_SCAN: begin
                    if (!scan_req) begin
                        state_d = ST_HOLD;
                        idx_d   = sel_in;
                        cnt_d   = '0;
                    end else if (cnt_q >= dwell) begin
                        cnt_d = '0;
                        if (mode == MODE_UP) begin
                            idx_d  = idx_q + 1'b1;
                            wrap_d = (idx_q == '1);
                        end else begin
                            idx_d  = idx_q - 1'b1;
                            wrap_d = (idx_q == '0);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    clr_y   = 1'b1;
                end
            endcase
        end
        therm_d = (state_d == ST_HOLD) && (mode == MODE_THERM);
        y_d     = clr_y ? '0 : y_dec;
    end

    dec_onehot_comb #(.SEL_W(SEL_W)) u_dec (
        .idx_next (idx_d),
        .therm    (therm_d),
        .y_next   (y_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
            busy_q  <= (state_d == ST_SCAN);
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign busy = busy_q;

endmodule
